// File: rtl/cipher_load_sequencer.sv
// Load sequencer for the lightweight cipher core: captures one plaintext block and key per
// request, serialises them as DATAW-bit words, holds the core for WAIT_CYC cycles, then
// pulses save. Optional feature macro: CIPHER_KEY_REUSE_EN (honour key_keep to skip the key load).
module cipher_load_sequencer #(
  parameter int unsigned DATAW    = 10,
  parameter int unsigned DWORDS   = 2,
  parameter int unsigned KWORDS   = 4,
  parameter int unsigned WAIT_CYC = 31
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     income,
  input  logic                     key_keep,
  input  logic [DWORDS*DATAW-1:0]  Data,
  input  logic [KWORDS*DATAW-1:0]  Key,
  output logic                     in_ready,
  output logic [DATAW-1:0]         keyout,
  output logic [DATAW-1:0]         dataout,
  output logic                     kctr,
  output logic                     dctr,
  output logic                     save,
  output logic                     set,
  output logic                     lfsrset
);

  localparam int unsigned MaxCnt  = (KWORDS > WAIT_CYC) ? KWORDS : WAIT_CYC;
  localparam int unsigned CntW    = $clog2(MaxCnt + 1);
  localparam int unsigned DataOff = KWORDS - DWORDS;

  localparam logic [CntW-1:0] KLast    = CntW'(KWORDS - 1);
  localparam logic [CntW-1:0] DLast    = CntW'(DWORDS - 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_CYC - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DWORDS*DATAW-1:0] data_q, data_d;
  logic [KWORDS*DATAW-1:0] key_q, key_d;
  logic                    reuse_q, reuse_d;
  logic                    in_ready_q, in_ready_d;
  logic [DATAW-1:0]        keyout_q, keyout_d;
  logic [DATAW-1:0]        dataout_q, dataout_d;
  logic                    kctr_q, kctr_d;
  logic                    dctr_q, dctr_d;
  logic                    save_q, save_d;
  logic                    set_q, set_d;
  logic                    lfsrset_q, lfsrset_d;

  logic accept;
  logic reuse_req;

  assign accept = income & in_ready_q;

`ifdef CIPHER_KEY_REUSE_EN
  logic kvalid_q, kvalid_d;
  // A key may only be reused once a full key has actually reached the core.
  assign reuse_req = key_keep & kvalid_q;
`else
  logic unused_key_keep;
  assign unused_key_keep = key_keep;
  assign reuse_req       = 1'b0;
`endif

  // Next-state, capture and registered-output logic.
  always_comb begin
    logic                    start;
    logic                    drive;
    logic                    ld_reuse;
    int unsigned             idx;
    logic [DWORDS*DATAW-1:0] src_data;
    logic [KWORDS*DATAW-1:0] src_key;

    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    key_d      = key_q;
    reuse_d    = reuse_q;
    in_ready_d = 1'b0;
    keyout_d   = keyout_q;
    dataout_d  = dataout_q;
    kctr_d     = 1'b0;
    dctr_d     = 1'b0;
    save_d     = 1'b0;
    set_d      = 1'b0;
    lfsrset_d  = 1'b1;
`ifdef CIPHER_KEY_REUSE_EN
    kvalid_d   = kvalid_q;
`endif
    start    = 1'b0;
    drive    = 1'b0;
    ld_reuse = reuse_q;
    idx      = 0;
    src_data = data_q;
    src_key  = key_q;

    case (state_q)
      StIdle: begin
        set_d      = 1'b1;
        in_ready_d = 1'b1;
        start      = accept;
      end
      StLoad: begin
        if (cnt_q == (reuse_q ? DLast : KLast)) begin
          state_d    = StWait;
          cnt_d      = '0;
          lfsrset_d  = 1'b0;
          in_ready_d = (WAIT_CYC == 1);
`ifdef CIPHER_KEY_REUSE_EN
          if (!reuse_q) kvalid_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
          drive = 1'b1;
          idx   = 32'(cnt_q) + 32'd1;
        end
      end
      StWait: begin
        lfsrset_d = 1'b0;
        if (cnt_q == WaitLast) begin
          save_d    = 1'b1;
          lfsrset_d = 1'b1;
          cnt_d     = '0;
          if (accept) begin
            start = 1'b1;
          end else begin
            state_d    = StIdle;
            set_d      = 1'b1;
            in_ready_d = 1'b1;
          end
        end else begin
          cnt_d      = cnt_q + CntW'(1);
          in_ready_d = (cnt_q + CntW'(1) == WaitLast);
        end
      end
      default: state_d = StIdle;
    endcase

    // Word 0 comes straight from the inputs since the capture registers fill on this edge.
    if (start) begin
      state_d    = StLoad;
      cnt_d      = '0;
      data_d     = Data;
      reuse_d    = reuse_req;
      if (!reuse_req) key_d = Key;
      src_data   = Data;
      src_key    = Key;
      ld_reuse   = reuse_req;
      idx        = 0;
      drive      = 1'b1;
      set_d      = 1'b0;
      in_ready_d = 1'b0;
      lfsrset_d  = 1'b1;
    end

    // Data words line up with the last DWORDS key words; on reuse only data is sent.
    if (drive) begin
      if (ld_reuse) begin
        dctr_d    = 1'b1;
        dataout_d = src_data[idx*DATAW +: DATAW];
      end else begin
        kctr_d   = 1'b1;
        keyout_d = src_key[idx*DATAW +: DATAW];
        if (idx >= DataOff) begin
          dctr_d    = 1'b1;
          dataout_d = src_data[(idx-DataOff)*DATAW +: DATAW];
        end
      end
    end
  end

  // State and output registers; reset discards any captured block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      data_q     <= '0;
      key_q      <= '0;
      reuse_q    <= 1'b0;
      in_ready_q <= 1'b1;
      keyout_q   <= '0;
      dataout_q  <= '0;
      kctr_q     <= 1'b0;
      dctr_q     <= 1'b0;
      save_q     <= 1'b0;
      set_q      <= 1'b1;
      lfsrset_q  <= 1'b1;
`ifdef CIPHER_KEY_REUSE_EN
      kvalid_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      key_q      <= key_d;
      reuse_q    <= reuse_d;
      in_ready_q <= in_ready_d;
      keyout_q   <= keyout_d;
      dataout_q  <= dataout_d;
      kctr_q     <= kctr_d;
      dctr_q     <= dctr_d;
      save_q     <= save_d;
      set_q      <= set_d;
      lfsrset_q  <= lfsrset_d;
`ifdef CIPHER_KEY_REUSE_EN
      kvalid_q   <= kvalid_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign keyout   = keyout_q;
  assign dataout  = dataout_q;
  assign kctr     = kctr_q;
  assign dctr     = dctr_q;
  assign save     = save_q;
  assign set      = set_q;
  assign lfsrset  = lfsrset_q;

endmodule

// File: tb/tb_cipher_load_sequencer.sv
// Directed bench for cipher_load_sequencer: default instance plus a 1/1/1 instance.
module tb_cipher_load_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance
  logic        income, key_keep;
  logic [19:0] Data;
  logic [39:0] Key;
  logic        in_ready, kctr, dctr, save, set, lfsrset;
  logic [9:0]  keyout, dataout;

  cipher_load_sequencer dut (
    .clk(clk), .rst_n(rst_n), .income(income), .key_keep(key_keep), .Data(Data), .Key(Key),
    .in_ready(in_ready), .keyout(keyout), .dataout(dataout), .kctr(kctr), .dctr(dctr),
    .save(save), .set(set), .lfsrset(lfsrset)
  );

  // Minimal instance: one data word, one key word, one wait cycle
  logic       s_income, s_key_keep;
  logic [9:0] s_data, s_key, s_keyout, s_dataout;
  logic       s_in_ready, s_kctr, s_dctr, s_save, s_set, s_lfsrset;

  cipher_load_sequencer #(.DATAW(10), .DWORDS(1), .KWORDS(1), .WAIT_CYC(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .income(s_income), .key_keep(s_key_keep), .Data(s_data),
    .Key(s_key), .in_ready(s_in_ready), .keyout(s_keyout), .dataout(s_dataout),
    .kctr(s_kctr), .dctr(s_dctr), .save(s_save), .set(s_set), .lfsrset(s_lfsrset)
  );

  localparam logic [39:0] KeyV = {10'h004, 10'h003, 10'h002, 10'h001};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  // {in_ready, kctr, dctr, save, set, lfsrset}
  function automatic logic [5:0] st_now();
    return {in_ready, kctr, dctr, save, set, lfsrset};
  endfunction

  function automatic logic [5:0] st_small();
    return {s_in_ready, s_kctr, s_dctr, s_save, s_set, s_lfsrset};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) wait_edge();
    n_tests++;
    if (st_now() !== 6'b100011) begin
      n_fail++; $display("FAIL reset_status: got %b want %b", st_now(), 6'b100011);
    end
    n_tests++;
    if ({keyout, dataout} !== 20'h0) begin
      n_fail++; $display("FAIL reset_words: got %h/%h want 000/000", keyout, dataout);
    end
    rst_n = 1'b1;
    wait_edge();
    n_tests++;
    if (st_now() !== 6'b100011) begin
      n_fail++; $display("FAIL idle_status: got %b want %b", st_now(), 6'b100011);
    end
  endtask

  // One request from idle; inputs are scrambled after accept to prove capture.
  task automatic test_load(input string name, input logic kk, input logic exp_reuse,
                           input logic [19:0] dat);
    int         nl;
    logic       exp_dctr;
    logic [5:0] exp_st;
    logic [9:0] w0, w1, exp_ko, exp_do;
    nl = exp_reuse ? 2 : 4;
    w0 = dat[9:0];
    w1 = dat[19:10];
    Data = dat; Key = KeyV; key_keep = kk; income = 1'b1;
    wait_edge();
    income = 1'b0; key_keep = 1'b0; Data = 20'hFFFFF; Key = '1;
    for (int i = 0; i < nl; i++) begin
      if (i > 0) wait_edge();
      exp_dctr = exp_reuse || (i >= 2);
      exp_st   = {1'b0, !exp_reuse, exp_dctr, 1'b0, 1'b0, 1'b1};
      n_tests++;
      if (st_now() !== exp_st) begin
        n_fail++; $display("FAIL %s load%0d status: got %b want %b", name, i, st_now(), exp_st);
      end
      exp_ko = exp_reuse ? 10'h004 : 10'(i + 1);
      n_tests++;
      if (keyout !== exp_ko) begin
        n_fail++; $display("FAIL %s load%0d keyout: got %h want %h", name, i, keyout, exp_ko);
      end
      if (exp_dctr) begin
        exp_do = (nl - 1 == i) ? w1 : w0;
        n_tests++;
        if (dataout !== exp_do) begin
          n_fail++; $display("FAIL %s load%0d dataout: got %h want %h", name, i, dataout, exp_do);
        end
      end
    end
    for (int j = 0; j < 31; j++) begin
      wait_edge();
      exp_st = {(j == 30), 5'b00000};
      n_tests++;
      if (st_now() !== exp_st) begin
        n_fail++; $display("FAIL %s wait%0d status: got %b want %b", name, j, st_now(), exp_st);
      end
      n_tests++;
      if ({keyout, dataout} !== {10'h004, w1}) begin
        n_fail++; $display("FAIL %s wait%0d hold: got %h/%h want 004/%h", name, j, keyout,
                           dataout, w1);
      end
    end
    wait_edge();
    n_tests++;
    if (st_now() !== 6'b100111) begin
      n_fail++; $display("FAIL %s save: got %b want %b", name, st_now(), 6'b100111);
    end
    wait_edge();
    n_tests++;
    if (st_now() !== 6'b100011) begin
      n_fail++; $display("FAIL %s post_save: got %b want %b", name, st_now(), 6'b100011);
    end
  endtask

  task automatic test_back_to_back();
    Data = 20'h12345; Key = KeyV; key_keep = 1'b0; income = 1'b1;
    wait_edge();
    for (int c = 1; c < 35; c++) begin
      wait_edge();
      n_tests++;
      if ({set, save, in_ready} !== {2'b00, (c == 34)}) begin
        n_fail++; $display("FAIL b2b c%0d set/save/rdy: got %b want %b", c, {set, save, in_ready},
                           {2'b00, (c == 34)});
      end
    end
    wait_edge();
    n_tests++;
    if (st_now() !== 6'b010101) begin
      n_fail++; $display("FAIL b2b overlap status: got %b want %b", st_now(), 6'b010101);
    end
    n_tests++;
    if (keyout !== 10'h001) begin
      n_fail++; $display("FAIL b2b overlap keyout: got %h want 001", keyout);
    end
    income = 1'b0;
    for (int c = 36; c < 70; c++) begin
      wait_edge();
      n_tests++;
      if ({set, save} !== 2'b00) begin
        n_fail++; $display("FAIL b2b c%0d set/save: got %b want 00", c, {set, save});
      end
    end
    wait_edge();
    n_tests++;
    if (st_now() !== 6'b100111) begin
      n_fail++; $display("FAIL b2b second save: got %b want %b", st_now(), 6'b100111);
    end
    wait_edge();
  endtask

  task automatic test_reset_mid();
    int saves;
    saves = 0;
    Data = 20'h12345; Key = KeyV; key_keep = 1'b0; income = 1'b1;
    wait_edge();
    income = 1'b0;
    repeat (14) wait_edge();
    n_tests++;
    if (lfsrset !== 1'b0) begin
      n_fail++; $display("FAIL midrst in_wait lfsrset: got %b want 0", lfsrset);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (st_now() !== 6'b100011) begin
      n_fail++; $display("FAIL midrst async status: got %b want %b", st_now(), 6'b100011);
    end
    n_tests++;
    if ({keyout, dataout} !== 20'h0) begin
      n_fail++; $display("FAIL midrst async words: got %h/%h want 000/000", keyout, dataout);
    end
    repeat (2) wait_edge();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      wait_edge();
      if (save) saves++;
    end
    n_tests++;
    if (saves !== 0) begin
      n_fail++; $display("FAIL midrst saves: got %0d want 0", saves);
    end
  endtask

  task automatic test_small();
    s_data = 10'h2AA; s_key = 10'h155; s_income = 1'b1;
    wait_edge();
    s_income = 1'b0; s_data = 10'h0F0; s_key = 10'h30F;
    n_tests++;
    if (st_small() !== 6'b011001) begin
      n_fail++; $display("FAIL small load status: got %b want %b", st_small(), 6'b011001);
    end
    n_tests++;
    if ({s_keyout, s_dataout} !== {10'h155, 10'h2AA}) begin
      n_fail++; $display("FAIL small load words: got %h/%h want 155/2aa", s_keyout, s_dataout);
    end
    wait_edge();
    n_tests++;
    if (st_small() !== 6'b100000) begin
      n_fail++; $display("FAIL small wait status: got %b want %b", st_small(), 6'b100000);
    end
    n_tests++;
    if (s_dataout !== 10'h2AA) begin
      n_fail++; $display("FAIL small wait dataout: got %h want 2aa", s_dataout);
    end
    wait_edge();
    n_tests++;
    if (st_small() !== 6'b100111) begin
      n_fail++; $display("FAIL small save: got %b want %b", st_small(), 6'b100111);
    end
    wait_edge();
    n_tests++;
    if (s_save !== 1'b0) begin
      n_fail++; $display("FAIL small save_pulse: got %b want 0", s_save);
    end
  endtask

  initial begin
    logic reuse_exp;
`ifdef CIPHER_KEY_REUSE_EN
    reuse_exp = 1'b1;
`else
    reuse_exp = 1'b0;
`endif
    income = 1'b0; key_keep = 1'b0; Data = '0; Key = '0;
    s_income = 1'b0; s_key_keep = 1'b0; s_data = '0; s_key = '0;
    test_reset();
    test_load("first_keep", 1'b1, 1'b0, 20'h12345);
    test_load("reuse", 1'b1, reuse_exp, 20'hABCDE);
    test_load("full", 1'b0, 1'b0, 20'h5A3C7);
    test_back_to_back();
    test_reset_mid();
    test_load("after_rst", 1'b1, 1'b0, 20'h12345);
    test_small();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/cipher_load_sequencer.md
# cipher_load_sequencer

Parametrised load sequencer feeding the lightweight cipher core: accepts one plaintext block and one key per request, serialises them into DATAW-bit words on keyout/dataout with kctr/dctr strobes, holds the core for a fixed round interval, then pulses save. Successor to the fixed 2-data/4-key loader. Adds configurable word counts and wait length, input capture, a ready handshake, back-to-back requests, asynchronous reset and optional key reuse.

## Interface
- DATAW, 10, word width in bits
- DWORDS, 2, data words per block (1..KWORDS)
- KWORDS, 4, key words per key (>=1)
- WAIT_CYC, 31, round-interval cycles between end of load and save (>=1)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset: asynchronous, active-low
- income  in  1  request; accepted when income && in_ready at a clk edge
- key_keep  in  1  sampled with income; reuse previously loaded key (KEY_REUSE_EN only)
- Data  in  DWORDS*DATAW  plaintext; word i = Data[i*DATAW +: DATAW]
- Key  in  KWORDS*DATAW  key; word i = Key[i*DATAW +: DATAW]
- in_ready  out  1  sequencer can accept a request this cycle
- keyout  out  DATAW  current key word
- dataout  out  DATAW  current data word
- kctr  out  1  keyout valid this cycle
- dctr  out  1  dataout valid this cycle
- save  out  1  one-cycle pulse: core result ready to store
- set  out  1  high while idle (core held)
- lfsrset  out  1  low only during WAIT (LFSR runs)

## Operation
- States: IDLE, LOAD, WAIT. All outputs registered.
- Reset values: state IDLE, in_ready 1, keyout 0, dataout 0, kctr 0, dctr 0, save 0, set 1, lfsrset 1, counter 0, key-valid flag 0.
- IDLE: set=1, in_ready=1. On accept: capture Data/Key into internal registers, set=0, go LOAD. Later input changes do not affect the block.
- LOAD, full key (NL=KWORDS cycles, index i=0..NL-1): keyout=key word i, kctr=1. dctr=1 and dataout=data word i-(KWORDS-DWORDS) for i>=KWORDS-DWORDS, else dctr=0. Data words are therefore aligned to the last DWORDS key words.
- LOAD, key reused (NL=DWORDS cycles): kctr=0, keyout holds its last value, dctr=1, dataout=data word i.
- Sets the key-valid flag after the first full-key load.
- WAIT: kctr=dctr=0, lfsrset=0, for WAIT_CYC cycles. in_ready=1 only in the last WAIT cycle.
- Completion, at the edge ending WAIT: save=1 for one cycle and lfsrset=1.
  - If income was accepted at that edge: capture and go LOAD (index 0 is driven in the same cycle as save).
  - Otherwise: go IDLE with set=1.
- in_ready=0 in LOAD and in non-final WAIT cycles; income there is ignored, not queued.
- key_keep while key-valid=0 is ignored; a full key load is performed.
- Counter: single up-counter, width $clog2(max(KWORDS,WAIT_CYC)+1). Cleared on every phase change. No wrap within a phase.
- Reset mid-operation: immediate return to reset values. Captured words are discarded and no save is issued.

## Timing
- Accept at edge E0 → first load word valid in the cycle after E0.
- LOAD spans NL cycles; WAIT spans WAIT_CYC cycles.
- save is high in the cycle after edge E0+NL+WAIT_CYC.
- Back-to-back throughput: one block per NL+WAIT_CYC cycles, with no idle bubble.
- Default parameters, full key: save follows accept after 35 edges.

## Configuration
- CIPHER_KEY_REUSE_EN defined: key_keep honoured as above; key-valid flag implemented.
- Not defined: key_keep is ignored and every request performs a full KWORDS key load.

## Test plan
- Defaults; K words 0x001..0x004, Data = 20'h12345 → keyout 001,002,003,004 with kctr=1 over 4 cycles; dctr=1 only in cycles 3–4 with dataout 0x345 then 0x048; save 31 cycles after the last load cycle; set=1 afterwards.
- income held high → second block's key word 0x001 appears in the same cycle as the first save; period 35 cycles; no IDLE cycle between blocks.
- CIPHER_KEY_REUSE_EN, second request with key_keep=1 → 2 load cycles, kctr=0, keyout stays 0x004; save 33 edges after accept. Same request without the macro → full 4-word load.
- key_keep=1 on the first request after reset → full key load.
- rst_n low at WAIT cycle 10 → outputs go to reset values asynchronously; no save pulse; the next request loads normally.
- Parameters DWORDS=1, KWORDS=1, WAIT_CYC=1 → single load cycle with kctr=dctr=1; save 2 edges after accept; change Data after accept → dataout unaffected.
